greater_than: RTL and testbench

- Registered magnitude comparator: asserts `f` when operand `a` is strictly greater than operand `b`.
- Also provides equal and less-than flags.
- Pipelined with a valid qualifier, so it drops into datapath compare stages and decision logic.
- Default configuration is the 2-bit unsigned comparator used across the design.

---
 rtl/greater_than.sv | 78 +++++++
 tb/tb_greater_than.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/greater_than.sv
`default_nettype none
// ============================================================================
//  Module   : greater_than
//  Purpose  : Pipelined magnitude comparator producing one-hot a>b / a==b /
//             a<b flags with a matching valid qualifier.
//  Revision : 1.0  initial release
// ============================================================================
module greater_than #(
    parameter int WIDTH   = 2,
    parameter int SIGNED  = 0,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             f,
    output logic             eq,
    output logic             lt
);

    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_sign_mask = (SIGNED != 0) ? (c_one << (WIDTH - 1)) : '0;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a single unsigned comparator serves both modes.
    logic [WIDTH-1:0] w_a_key;
    logic [WIDTH-1:0] w_b_key;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;

    assign w_a_key = a ^ c_sign_mask;
    assign w_b_key = b ^ c_sign_mask;
    assign w_gt    = (w_a_key > w_b_key);
    assign w_eq    = (w_a_key == w_b_key);
    assign w_lt    = ~w_gt & ~w_eq;

    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] r_gt;
    logic [LATENCY-1:0] r_eq;
    logic [LATENCY-1:0] r_lt;

    // Result registers load only behind a valid qualifier: bubbles leave the
    // last result in place and unqualified operands never enter the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_gt    <= '0;
            r_eq    <= '0;
            r_lt    <= '0;
        end else begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_gt[0] <= w_gt;
                r_eq[0] <= w_eq;
                r_lt[0] <= w_lt;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_gt[i] <= r_gt[i-1];
                    r_eq[i] <= r_eq[i-1];
                    r_lt[i] <= r_lt[i-1];
                end
            end
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign f         = r_gt[LATENCY-1];
    assign eq        = r_eq[LATENCY-1];
    assign lt        = r_lt[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_greater_than.sv
`default_nettype none
// ============================================================================
//  Module   : tb_greater_than
//  Purpose  : Self-checking bench for greater_than across several configs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_greater_than;

    logic       clk;
    logic       rst_n;
    logic       vld;
    logic [7:0] a8;
    logic [7:0] b8;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];

    logic def_ov, def_f, def_eq, def_lt;
    logic l2_ov, l2_f, l2_eq, l2_lt;
    logic l3_ov, l3_f, l3_eq, l3_lt;
    logic l4_ov, l4_f, l4_eq, l4_lt;
    logic s4_ov, s4_f, s4_eq, s4_lt;
    logic u4_ov, u4_f, u4_eq, u4_lt;
    logic u8_ov, u8_f, u8_eq, u8_lt;
    logic w1_ov, w1_f, w1_eq, w1_lt;
    logic w1s_ov, w1s_f, w1s_eq, w1s_lt;

    greater_than #(.WIDTH(2), .SIGNED(0), .LATENCY(1)) u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8[1:0]), .b(b8[1:0]),
        .out_valid(def_ov), .f(def_f), .eq(def_eq), .lt(def_lt));
    greater_than #(.WIDTH(2), .SIGNED(0), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8[1:0]), .b(b8[1:0]),
        .out_valid(l2_ov), .f(l2_f), .eq(l2_eq), .lt(l2_lt));
    greater_than #(.WIDTH(2), .SIGNED(0), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8[1:0]), .b(b8[1:0]),
        .out_valid(l3_ov), .f(l3_f), .eq(l3_eq), .lt(l3_lt));
    greater_than #(.WIDTH(2), .SIGNED(0), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8[1:0]), .b(b8[1:0]),
        .out_valid(l4_ov), .f(l4_f), .eq(l4_eq), .lt(l4_lt));
    greater_than #(.WIDTH(4), .SIGNED(1), .LATENCY(1)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8[3:0]), .b(b8[3:0]),
        .out_valid(s4_ov), .f(s4_f), .eq(s4_eq), .lt(s4_lt));
    greater_than #(.WIDTH(4), .SIGNED(0), .LATENCY(1)) u_u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8[3:0]), .b(b8[3:0]),
        .out_valid(u4_ov), .f(u4_f), .eq(u4_eq), .lt(u4_lt));
    greater_than #(.WIDTH(8), .SIGNED(0), .LATENCY(1)) u_u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8), .b(b8),
        .out_valid(u8_ov), .f(u8_f), .eq(u8_eq), .lt(u8_lt));
    greater_than #(.WIDTH(1), .SIGNED(0), .LATENCY(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8[0:0]), .b(b8[0:0]),
        .out_valid(w1_ov), .f(w1_f), .eq(w1_eq), .lt(w1_lt));
    greater_than #(.WIDTH(1), .SIGNED(1), .LATENCY(1)) u_w1s (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .a(a8[0:0]), .b(b8[0:0]),
        .out_valid(w1s_ov), .f(w1s_f), .eq(w1s_eq), .lt(w1s_lt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret operands as integers, then compare. Returns {gt,eq,lt}.
    function automatic logic [2:0] model(input int w, input bit sgn,
                                         input logic [7:0] av, input logic [7:0] bv);
        longint x, y, span;
        span = longint'(1) << w;
        x = longint'(av) % span;
        y = longint'(bv) % span;
        if (sgn && x >= span / 2) x = x - span;
        if (sgn && y >= span / 2) y = y - span;
        return {x > y, x == y, x < y};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus; returns 1 time unit after the capture edge.
    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv);
        vld = v;
        a8  = av;
        b8  = bv;
        if (v && rst_n) sb.push_back(model(2, 1'b0, av, bv));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer for the default configuration.
    always @(negedge clk) begin
        if (def_ov === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 8'd1, 8'd0);
            end else begin
                chk("sb_result", {5'd0, def_f, def_eq, def_lt}, {5'd0, sb.pop_front()});
            end
        end
    end

    localparam logic [15:0] c_f_tab  = 16'h7310;
    localparam logic [15:0] c_eq_tab = 16'h8421;

    initial begin
        logic [3:0] lat_ov;
        logic [3:0] lat_f;
        logic [15:0] f_tab;
        logic [15:0] eq_tab;
        f_tab  = c_f_tab;
        eq_tab = c_eq_tab;
        rst_n = 1'b0;
        vld   = 1'b0;
        a8    = 8'd0;
        b8    = 8'd0;
        @(posedge clk);
        #1;
        chk("reset_def", {4'd0, def_ov, def_f, def_eq, def_lt}, 8'd0);
        chk("reset_l4",  {4'd0, l4_ov, l4_f, l4_eq, l4_lt}, 8'd0);
        rst_n = 1'b1;
        drive(1'b0, 8'd0, 8'd0);
        chk("idle_ov", {7'd0, def_ov}, 8'd0);

        // Exhaustive default configuration
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i >> 2), 8'(i & 3));
            chk("exh_ov", {7'd0, def_ov}, 8'd1);
            chk("exh_flags", {5'd0, def_f, def_eq, def_lt},
                {5'd0, f_tab[i], eq_tab[i], ~(f_tab[i] | eq_tab[i])});
        end

        // Bubble: valid, idle, valid
        drive(1'b1, 8'd3, 8'd1);
        chk("bub1", {4'd0, def_ov, def_f, def_eq, def_lt}, 8'b1100);
        drive(1'b0, 8'd0, 8'd3);
        chk("bub_idle", {4'd0, def_ov, def_f, def_eq, def_lt}, 8'b0100);
        drive(1'b1, 8'd0, 8'd2);
        chk("bub2", {4'd0, def_ov, def_f, def_eq, def_lt}, 8'b1001);

        // Signed vs unsigned at WIDTH=4
        drive(1'b1, 8'h08, 8'h07);
        chk("s4_neg8_pos7", {4'd0, s4_ov, s4_f, s4_eq, s4_lt}, 8'b1001);
        chk("u4_8_7",       {4'd0, u4_ov, u4_f, u4_eq, u4_lt}, 8'b1100);
        drive(1'b1, 8'h0F, 8'h00);
        chk("s4_ones_zero", {5'd0, s4_f, s4_eq, s4_lt}, {5'd0, model(4, 1'b1, 8'h0F, 8'h00)});
        chk("u4_ones_zero", {5'd0, u4_f, u4_eq, u4_lt}, 8'b100);
        chk("u8_15_0",      {5'd0, u8_f, u8_eq, u8_lt}, 8'b100);
        chk("w1_1_0",       {4'd0, w1_ov, w1_f, w1_eq, w1_lt}, 8'b1100);
        chk("w1s_1_0",      {4'd0, w1s_ov, w1s_f, w1s_eq, w1s_lt}, 8'b1001);

        // WIDTH=8 extremes
        drive(1'b1, 8'd255, 8'd0);
        chk("u8_max_zero", {4'd0, u8_ov, u8_f, u8_eq, u8_lt}, 8'b1100);
        drive(1'b1, 8'd255, 8'd255);
        chk("u8_max_max", {5'd0, u8_f, u8_eq, u8_lt}, 8'b010);
        chk("s4_max_max", {5'd0, s4_f, s4_eq, s4_lt}, 8'b010);
        drive(1'b1, 8'd0, 8'd255);
        chk("u8_zero_max", {5'd0, u8_f, u8_eq, u8_lt}, 8'b001);
        chk("s4_zero_neg1", {5'd0, s4_f, s4_eq, s4_lt}, 8'b100);
        chk("w1s_0_1", {5'd0, w1s_f, w1s_eq, w1s_lt}, 8'b100);
        drive(1'b1, 8'd0, 8'd0);
        chk("u8_zero_zero", {5'd0, u8_f, u8_eq, u8_lt}, 8'b010);

        // Latency sweep: single pulse, flush first
        for (int i = 0; i < 5; i++) drive(1'b0, 8'd0, 8'd0);
        drive(1'b1, 8'd2, 8'd1);
        for (int k = 1; k <= 5; k++) begin
            lat_ov = {l4_ov, l3_ov, l2_ov, def_ov};
            lat_f  = {l4_f, l3_f, l2_f, def_f};
            for (int l = 1; l <= 4; l++) begin
                chk($sformatf("lat%0d_ov_k%0d", l, k), {7'd0, lat_ov[l-1]}, {7'd0, k == l});
                if (k == l) chk($sformatf("lat%0d_f", l), {7'd0, lat_f[l-1]}, 8'd1);
            end
            drive(1'b0, 8'd0, 8'd0);
        end

        // Reset mid-stream with samples in flight in the LATENCY=3 pipe
        drive(1'b1, 8'd3, 8'd0);
        drive(1'b1, 8'd3, 8'd0);
        drive(1'b1, 8'd3, 8'd0);
        chk("l3_pre_reset", {4'd0, l3_ov, l3_f, l3_eq, l3_lt}, 8'b1100);
        drive(1'b1, 8'd0, 8'd3);
        drive(1'b1, 8'd0, 8'd3);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("l3_async_rst",  {4'd0, l3_ov, l3_f, l3_eq, l3_lt}, 8'd0);
        chk("def_async_rst", {4'd0, def_ov, def_f, def_eq, def_lt}, 8'd0);
        drive(1'b0, 8'd0, 8'd0);
        drive(1'b0, 8'd0, 8'd0);
        chk("l3_in_rst", {4'd0, l3_ov, l3_f, l3_eq, l3_lt}, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'd0, 8'd0);
            chk("l3_no_ghost", {4'd0, l3_ov, l3_f, l3_eq, l3_lt}, 8'd0);
        end
        drive(1'b1, 8'd2, 8'd1);
        chk("l3_post_k1", {7'd0, l3_ov}, 8'd0);
        drive(1'b0, 8'd0, 8'd0);
        chk("l3_post_k2", {7'd0, l3_ov}, 8'd0);
        drive(1'b0, 8'd0, 8'd0);
        chk("l3_post_k3", {4'd0, l3_ov, l3_f, l3_eq, l3_lt}, 8'b1100);

        for (int i = 0; i < 3; i++) drive(1'b0, 8'd0, 8'd0);
        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
